fm_buf_ctrl: RTL

FM_BUF_CTRL -- requirements
Module: fm_buf_ctrl

---
 rtl/fm_pkg.sv | 15 +
 rtl/fm_addr_gen.sv | 23 ++
 rtl/fm_buf_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// Shared definitions for the feature-map buffer controller: FSM states and
// default geometry (16 banks x 16 words, read stride 4).
package fm_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } fm_state_e;

  localparam int FM_BANKS  = 16;
  localparam int FM_DEPTH  = 16;
  localparam int FM_STRIDE = 4;

endpackage

// File: rtl/fm_addr_gen.sv
// Interleaved read-address generator: maps read index k to the bank word address
// (k mod rows)*STRIDE + k div rows, and flags the last index of a bank.
module fm_addr_gen
  import fm_pkg::*;
#(
  parameter int DEPTH  = FM_DEPTH,
  parameter int STRIDE = FM_STRIDE
) (
  input  logic [$clog2(DEPTH)-1:0] k,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     wrap
);

  localparam int AW   = $clog2(DEPTH);
  localparam int ROWS = DEPTH / STRIDE;

  // ROWS and STRIDE are powers of two, so the div/mod reduce to bit slicing
  always_comb begin
    addr = AW'((int'(k) % ROWS) * STRIDE + int'(k) / ROWS);
    wrap = (k == AW'(DEPTH - 1));
  end

endmodule

// File: rtl/fm_buf_ctrl.sv
// Feature-map buffer controller: fills all banks in parallel, then drains them
// bank by bank in interleaved address order. Macro FM_BUF_CTRL_FRAME_CNT_EN adds o_frame_cnt.
module fm_buf_ctrl
  import fm_pkg::*;
#(
  parameter int BANKS  = FM_BANKS,
  parameter int DEPTH  = FM_DEPTH,
  parameter int STRIDE = FM_STRIDE
) (
  input  logic                     i_sclk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_in_ready,
  output logic                     o_wr_en,
  output logic [$clog2(DEPTH)-1:0] o_wr_addr,
  input  logic                     i_ready,
  output logic [BANKS-1:0]         o_rd_bank,
  output logic [$clog2(DEPTH)-1:0] o_rd_addr,
  output logic [BANKS-1:0]         o_sel,
  output logic                     o_rd_valid,
  output logic                     o_frame_done,
`ifdef FM_BUF_CTRL_FRAME_CNT_EN
  output logic [7:0]               o_frame_cnt,
`endif
  output fm_state_e                o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [BANKS-1:0] BANK_FIRST = BANKS'(1);

  fm_state_e        state, state_nxt;
  logic [AW-1:0]    wr_cnt, wr_cnt_nxt;
  logic [AW-1:0]    k, k_nxt;
  logic [BANKS-1:0] bank, bank_nxt;
  logic             k_wrap;

  fm_addr_gen #(.DEPTH(DEPTH), .STRIDE(STRIDE)) u_addr_gen (
    .k    (k),
    .addr (o_rd_addr),
    .wrap (k_wrap)
  );

  // Handshakes: a write beat transfers when i_valid & o_in_ready; a read is
  // issued when i_ready is high in DRAIN. Nothing moves on any other cycle.
  always_comb begin
    state_nxt    = state;
    wr_cnt_nxt   = wr_cnt;
    k_nxt        = k;
    bank_nxt     = bank;
    o_in_ready   = 1'b0;
    o_rd_bank    = '0;
    o_frame_done = 1'b0;
    case (state)
      ST_FILL: begin
        o_in_ready = 1'b1;
        if (i_valid) begin
          if (wr_cnt == AW'(DEPTH - 1)) begin
            wr_cnt_nxt = '0;
            state_nxt  = ST_DRAIN;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (i_ready) begin
          o_rd_bank = bank;
          if (k_wrap) begin
            k_nxt    = '0;
            bank_nxt = bank << 1;
            if (bank[BANKS-1]) state_nxt = ST_FLUSH;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        o_frame_done = 1'b1;
        bank_nxt     = BANK_FIRST;
        state_nxt    = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state  <= ST_FILL;
      wr_cnt <= '0;
      k      <= '0;
      bank   <= BANK_FIRST;
      o_sel  <= '0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
      k      <= k_nxt;
      bank   <= bank_nxt;
      o_sel  <= o_rd_bank;
    end
  end

  assign o_wr_en    = i_valid & o_in_ready;
  assign o_wr_addr  = wr_cnt;
  assign o_rd_valid = |o_sel;
  assign o_state    = state;

`ifdef FM_BUF_CTRL_FRAME_CNT_EN
  always_ff @(posedge i_sclk) begin
    if (i_rst)             o_frame_cnt <= '0;
    else if (o_frame_done) o_frame_cnt <= o_frame_cnt + 8'd1;
  end
`endif

endmodule
